// File: rtl/pipeline_stall_controller_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pipeline_stall_controller_pkg
// Purpose  : State encodings and control-word types for the stall sequencer.
// Revision : 1.0  initial release
// ============================================================================
package pipeline_stall_controller_pkg;

    localparam int c_PSC_STATE_W = 2;

    localparam logic [c_PSC_STATE_W-1:0] c_PSC_RUN      = 2'd0;
    localparam logic [c_PSC_STATE_W-1:0] c_PSC_MEM_WAIT = 2'd1;
    localparam logic [c_PSC_STATE_W-1:0] c_PSC_ERROR    = 2'd2;

    typedef struct packed {
        logic freeze_pc;
        logic freeze_if_id;
        logic bubble_id_exe;
        logic flush_if_id;
        logic freeze_back;
    } psc_ctrl_t;

    localparam psc_ctrl_t c_CTRL_IDLE       = psc_ctrl_t'(5'b00000);
    localparam psc_ctrl_t c_CTRL_FREEZE_ALL = psc_ctrl_t'(5'b11001);
    localparam psc_ctrl_t c_CTRL_FLUSH      = psc_ctrl_t'(5'b00110);
    localparam psc_ctrl_t c_CTRL_HAZARD     = psc_ctrl_t'(5'b11100);

endpackage
`default_nettype wire

// File: rtl/pipeline_stall_controller_if.sv
`default_nettype none
// ============================================================================
// Module   : pipeline_stall_controller_if
// Purpose  : Pipeline-side hazard/memory flags and register control outputs.
// Revision : 1.0  initial release
// ============================================================================
interface pipeline_stall_controller_if #(
    parameter int CNT_W = 16
);
    logic             hazard_detected;
    logic             branch_taken;
    logic             mem_access;
    logic             mem_ready;
    logic             freeze_pc;
    logic             freeze_if_id;
    logic             bubble_id_exe;
    logic             flush_if_id;
    logic             freeze_back;
    logic             wd_error;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;
    logic [CNT_W-1:0] wait_cnt;

    modport master (
        output hazard_detected, branch_taken, mem_access, mem_ready,
        input  freeze_pc, freeze_if_id, bubble_id_exe, flush_if_id, freeze_back,
        input  wd_error, stall_cnt, flush_cnt, wait_cnt
    );

    modport slave (
        input  hazard_detected, branch_taken, mem_access, mem_ready,
        output freeze_pc, freeze_if_id, bubble_id_exe, flush_if_id, freeze_back,
        output wd_error, stall_cnt, flush_cnt, wait_cnt
    );
endinterface
`default_nettype wire

// File: rtl/pipeline_stall_controller_sat_counter.sv
`default_nettype none
// ============================================================================
// Module   : sat_counter
// Purpose  : Up-counter that sticks at all-ones instead of wrapping.
// Revision : 1.0  initial release
// ============================================================================
module sat_counter #(
    parameter int W = 16
) (
    input  wire          clk,
    input  wire          rst_n,
    input  wire          inc,
    output logic [W-1:0] count
);
    logic [W-1:0] r_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (inc && (r_count != {W{1'b1}})) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign count = r_count;
endmodule
`default_nettype wire

// File: rtl/pipeline_stall_controller.sv
`default_nettype none
// ============================================================================
// Module   : pipeline_stall_controller
// Purpose  : Stall/flush sequencer with memory-wait watchdog. Performance
//            counters are built only when PIPE_PERF_CNT_EN is defined.
// Revision : 1.0  initial release
// ============================================================================
module pipeline_stall_controller
    import pipeline_stall_controller_pkg::*;
#(
    parameter int MEM_TIMEOUT = 64,
    parameter int TMO_W       = 7,
    parameter int CNT_W       = 16
) (
    input wire clk,
    input wire rst_n,
    pipeline_stall_controller_if.slave bus
);
    localparam logic [TMO_W-1:0] c_WD_LAST = TMO_W'(MEM_TIMEOUT - 1);
    localparam logic [TMO_W-1:0] c_WD_ONE  = TMO_W'(1);

    logic [c_PSC_STATE_W-1:0] r_state;
    logic [c_PSC_STATE_W-1:0] w_state_nxt;
    logic [TMO_W-1:0]         r_wd;
    logic [TMO_W-1:0]         w_wd_nxt;
    logic                     r_wd_error;
    logic                     w_wd_trip;
    logic                     w_mem_stall;
    psc_ctrl_t                w_ctrl;

    assign w_mem_stall = bus.mem_access && !bus.mem_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_PSC_RUN;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_wd_nxt    = r_wd;
        w_wd_trip   = 1'b0;
        case (r_state)
            c_PSC_RUN: begin
                if (w_mem_stall) begin
                    w_state_nxt = c_PSC_MEM_WAIT;
                    w_wd_nxt    = c_WD_ONE;
                end
            end
            c_PSC_MEM_WAIT: begin
                if (!w_mem_stall) begin
                    w_state_nxt = c_PSC_RUN;
                    w_wd_nxt    = '0;
                end else if (r_wd == c_WD_LAST) begin
                    // Trip before the counter can wrap.
                    w_state_nxt = c_PSC_ERROR;
                    w_wd_trip   = 1'b1;
                end else begin
                    w_wd_nxt = r_wd + 1'b1;
                end
            end
            c_PSC_ERROR: begin
                w_state_nxt = c_PSC_ERROR;
            end
            default: begin
                w_state_nxt = c_PSC_RUN;
                w_wd_nxt    = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wd       <= '0;
            r_wd_error <= 1'b0;
        end else begin
            r_wd <= w_wd_nxt;
            if (w_wd_trip) begin
                r_wd_error <= 1'b1;
            end
        end
    end

    // Priority: reset gate > error/mem-wait freeze > branch flush > hazard bubble.
    always_comb begin
        w_ctrl = c_CTRL_IDLE;
        if (!rst_n) begin
            w_ctrl = c_CTRL_IDLE;
        end else if ((r_state == c_PSC_ERROR) || w_mem_stall) begin
            w_ctrl = c_CTRL_FREEZE_ALL;
        end else if (bus.branch_taken) begin
            w_ctrl = c_CTRL_FLUSH;
        end else if (bus.hazard_detected) begin
            w_ctrl = c_CTRL_HAZARD;
        end
    end

    assign bus.freeze_pc     = w_ctrl.freeze_pc;
    assign bus.freeze_if_id  = w_ctrl.freeze_if_id;
    assign bus.bubble_id_exe = w_ctrl.bubble_id_exe;
    assign bus.flush_if_id   = w_ctrl.flush_if_id;
    assign bus.freeze_back   = w_ctrl.freeze_back;
    assign bus.wd_error      = r_wd_error;

`ifdef PIPE_PERF_CNT_EN
    logic w_stall_inc;

    // A bubble without a flush can only come from the hazard path.
    assign w_stall_inc = w_ctrl.bubble_id_exe && !w_ctrl.flush_if_id;

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (w_stall_inc),
        .count (bus.stall_cnt)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (w_ctrl.flush_if_id),
        .count (bus.flush_cnt)
    );

    sat_counter #(.W(CNT_W)) u_wait_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (w_ctrl.freeze_back),
        .count (bus.wait_cnt)
    );
`else
    assign bus.stall_cnt = {CNT_W{1'b0}};
    assign bus.flush_cnt = {CNT_W{1'b0}};
    assign bus.wait_cnt  = {CNT_W{1'b0}};
`endif

endmodule
`default_nettype wire
